// File: rtl/alu_op_sequencer.sv
// Multi-cycle execute controller for an external 8-bit combinational ALU.
// Owns a small register file; implements MUL as repeated ALU ADD.
module alu_op_sequencer #(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [3:0]        ins_op,
    input  logic [ADDR_W-1:0] ins_rd,
    input  logic [ADDR_W-1:0] ins_rs,
    input  logic [7:0]        ins_imm,
    output logic [2:0]        alu_sel,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    input  logic [7:0]        alu_c,
    output logic              done,
    output logic              err,
    output logic [7:0]        result,
    output logic              busy,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    localparam int unsigned NREG = 2**ADDR_W;

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t            state;
    logic [7:0]        regs [NREG];
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [7:0]        acc;
    logic [7:0]        cnt;
    logic [7:0]        mcand;
    logic [7:0]        rd_val;
    logic [7:0]        rs_val;
    logic [7:0]        opb_val;

    assign rd_val    = regs[ins_rd];
    assign rs_val    = regs[ins_rs];
    assign opb_val   = (ins_op == 4'd7) ? ins_imm : rs_val;
    assign ins_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign dbg_data  = regs[dbg_addr];

    // ALU drive registers are loaded one edge early so they are stable
    // for the whole cycle in which alu_c is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= '0;
            alu_sel <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            acc     <= '0;
            cnt     <= '0;
            mcand   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ins_valid && ins_ready) begin
                        op_q <= ins_op;
                        rd_q <= ins_rd;
                        if (ins_op == 4'd8) begin
                            state   <= MUL;
                            acc     <= '0;
                            cnt     <= rs_val;
                            mcand   <= rd_val;
                            alu_a   <= '0;
                            alu_sel <= (rs_val != 8'd0) ? 3'd5 : 3'd0;
                            alu_b   <= (rs_val != 8'd0) ? rd_val : 8'd0;
                        end else begin
                            state <= EXEC;
                            if (ins_op <= 4'd7) begin
                                alu_sel <= (ins_op == 4'd7) ? 3'd0 : ins_op[2:0];
                                alu_a   <= rd_val;
                                alu_b   <= opb_val;
                            end else begin
                                alu_sel <= '0;
                                alu_a   <= '0;
                                alu_b   <= '0;
                            end
                        end
                    end
                end
                EXEC: begin
                    if (op_q <= 4'd7) begin
                        regs[rd_q] <= alu_c;
                        result     <= alu_c;
                    end
                    err     <= (op_q > 4'd7);
                    done    <= 1'b1;
                    alu_sel <= '0;
                    alu_a   <= '0;
                    alu_b   <= '0;
                    state   <= IDLE;
                end
                MUL: begin
                    if (cnt != 8'd0) begin
                        acc <= alu_c;
                        cnt <= cnt - 8'd1;
                        // Last addition: release the ALU for the writeback cycle.
                        if (cnt == 8'd1) begin
                            alu_sel <= '0;
                            alu_a   <= '0;
                            alu_b   <= '0;
                        end else begin
                            alu_a <= alu_c;
                        end
                    end else begin
                        regs[rd_q] <= acc;
                        result     <= acc;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: table vectors, corner sequences and random
// instructions checked against an instruction-level register-file model.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       ins_valid;
    logic       ins_ready;
    logic [3:0] ins_op;
    logic [1:0] ins_rd;
    logic [1:0] ins_rs;
    logic [7:0] ins_imm;
    logic [2:0] alu_sel;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_c;
    logic       done;
    logic       err;
    logic [7:0] result;
    logic       busy;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] mr [4];
    logic [7:0] mres;

    always #5 clk = ~clk;

    // External ALU: 0 PASS B, 1 NOT A, 2 AND, 3 OR, 4 XOR, 5 ADD, 6 SUB
    always_comb begin
        case (alu_sel)
            3'd0:    alu_c = alu_b;
            3'd1:    alu_c = ~alu_a;
            3'd2:    alu_c = alu_a & alu_b;
            3'd3:    alu_c = alu_a | alu_b;
            3'd4:    alu_c = alu_a ^ alu_b;
            3'd5:    alu_c = alu_a + alu_b;
            3'd6:    alu_c = alu_a - alu_b;
            default: alu_c = 8'h00;
        endcase
    end

    alu_op_sequencer #(.ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_op(ins_op), .ins_rd(ins_rd), .ins_rs(ins_rs), .ins_imm(ins_imm),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .done(done), .err(err), .result(result), .busy(busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic logic [7:0] ref_op(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] imm);
        logic [15:0] p;
        case (op)
            4'd0: return b;
            4'd1: return ~a;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a + b;
            4'd6: return a - b;
            4'd7: return imm;
            4'd8: begin p = 16'(a) * 16'(b); return p[7:0]; end
            default: return mres;
        endcase
    endfunction

    task automatic check_regs(input string name);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk(name, int'(dbg_data), int'(mr[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mr[i] = 8'h00;
        mres = 8'h00;
    endtask

    // Issue one instruction, wait for its retire, compare against the model.
    task automatic run_ins(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                           input logic [7:0] imm, output logic [7:0] got_val,
                           output logic got_err, output int got_busy);
        logic [7:0] a, b, ev;
        logic       legal;
        int         eb, cyc, wait_n;
        int         exp_sel, exp_b;
        a     = mr[rd];
        b     = mr[rs];
        legal = (op <= 4'd8);
        ev    = ref_op(op, a, b, imm);
        eb    = (op == 4'd8) ? int'(b) + 1 : 1;
        if (op == 4'd8) begin
            exp_sel = (b != 0) ? 5 : 0;
            exp_b   = (b != 0) ? int'(a) : 0;
        end else if (!legal) begin
            exp_sel = 0; exp_b = 0;
        end else if (op == 4'd7) begin
            exp_sel = 0; exp_b = int'(imm);
        end else begin
            exp_sel = int'(op); exp_b = int'(b);
        end
        got_busy = 0;
        @(negedge clk);
        ins_op = op; ins_rd = rd; ins_rs = rs; ins_imm = imm; ins_valid = 1'b1;
        wait_n = 0;
        while (!ins_ready && wait_n < 400) begin @(negedge clk); wait_n++; end
        if (!ins_ready) begin
            chk("accept_timeout", 0, 1);
            ins_valid = 1'b0; got_val = result; got_err = err;
            return;
        end
        @(negedge clk);
        ins_valid = 1'b0;
        cyc = 1;
        chk("alu_sel_first_cycle", int'(alu_sel), exp_sel);
        chk("alu_b_first_cycle", int'(alu_b), exp_b);
        chk("busy_in_flight", int'(busy), 1);
        while (!done && cyc < 400) begin @(negedge clk); cyc++; end
        got_busy = cyc - 1;
        chk("done_pulse", int'(done), 1);
        chk("busy_cycles", got_busy, eb);
        chk("err", int'(err), legal ? 0 : 1);
        if (legal) begin
            mr[rd] = ev;
            mres   = ev;
        end
        chk("result", int'(result), int'(mres));
        chk("ready_after_retire", int'(ins_ready), 1);
        got_val = result;
        got_err = err;
        check_regs("regfile");
    endtask

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
        logic [7:0] exp_val;
        logic       exp_err;
        int         exp_busy;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [7:0] gv;
        logic       ge;
        int         gb;
        int         ndone, k, early_rdy, mul_cyc, ldi_cyc, cyc, npulse;
        logic       rdy;
        logic [3:0] bop [4];
        logic [1:0] brd [4];
        logic [1:0] brs [4];
        logic [7:0] bimm [4];
        logic [7:0] bexp [4];
        int         acc_cyc [4];

        tbl[0]  = '{4'd7, 2'd0, 2'd0, 8'h3C, 8'h3C, 1'b0, 1};
        tbl[1]  = '{4'd7, 2'd1, 2'd0, 8'h0F, 8'h0F, 1'b0, 1};
        tbl[2]  = '{4'd5, 2'd0, 2'd1, 8'h00, 8'h4B, 1'b0, 1};
        tbl[3]  = '{4'd7, 2'd2, 2'd0, 8'h05, 8'h05, 1'b0, 1};
        tbl[4]  = '{4'd7, 2'd3, 2'd0, 8'h07, 8'h07, 1'b0, 1};
        tbl[5]  = '{4'd6, 2'd2, 2'd3, 8'h00, 8'hFE, 1'b0, 1};
        tbl[6]  = '{4'd4, 2'd2, 2'd2, 8'h00, 8'h00, 1'b0, 1};
        tbl[7]  = '{4'd1, 2'd1, 2'd1, 8'h00, 8'hF0, 1'b0, 1};
        tbl[8]  = '{4'd7, 2'd0, 2'd0, 8'h0D, 8'h0D, 1'b0, 1};
        tbl[9]  = '{4'd7, 2'd1, 2'd0, 8'h14, 8'h14, 1'b0, 1};
        tbl[10] = '{4'd8, 2'd0, 2'd1, 8'h00, 8'h04, 1'b0, 21};
        tbl[11] = '{4'hB, 2'd0, 2'd1, 8'h99, 8'h04, 1'b1, 1};
        tbl[12] = '{4'd7, 2'd1, 2'd0, 8'h00, 8'h00, 1'b0, 1};
        tbl[13] = '{4'd8, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0, 1};
        tbl[14] = '{4'd3, 2'd2, 2'd3, 8'h00, 8'h07, 1'b0, 1};
        tbl[15] = '{4'd2, 2'd3, 2'd0, 8'h00, 8'h00, 1'b0, 1};
        tbl[16] = '{4'd0, 2'd3, 2'd2, 8'h00, 8'h07, 1'b0, 1};

        reset = 1'b1; ins_valid = 1'b0; ins_op = '0; ins_rd = '0; ins_rs = '0;
        ins_imm = '0; dbg_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(ins_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_alu_sel", int'(alu_sel), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_b", int'(alu_b), 0);
        check_regs("rst_regs");

        for (int i = 0; i < 17; i++) begin
            run_ins(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].imm, gv, ge, gb);
            chk("tbl_value", int'(gv), int'(tbl[i].exp_val));
            chk("tbl_err", int'(ge), int'(tbl[i].exp_err));
            chk("tbl_busy", gb, tbl[i].exp_busy);
        end

        // Held ins_valid across a MUL: the next instruction waits for its done.
        run_ins(4'd7, 2'd0, 2'd0, 8'h03, gv, ge, gb);
        run_ins(4'd7, 2'd1, 2'd0, 8'h05, gv, ge, gb);
        run_ins(4'd7, 2'd3, 2'd0, 8'h11, gv, ge, gb);
        @(negedge clk);
        ins_op = 4'd8; ins_rd = 2'd0; ins_rs = 2'd1; ins_valid = 1'b1;
        @(negedge clk);
        ins_op = 4'd7; ins_rd = 2'd3; ins_imm = 8'h77;
        cyc = 1; ndone = 0; early_rdy = 0; mul_cyc = -1; ldi_cyc = -1;
        while (ndone < 2 && cyc < 60) begin
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    mul_cyc = cyc;
                    chk("held_ready_at_done", int'(ins_ready), 1);
                    chk("held_mul_result", int'(result), 15);
                    dbg_addr = 2'd3; #1;
                    chk("held_r3_untouched", int'(dbg_data), 8'h11);
                end else begin
                    ldi_cyc = cyc;
                end
            end else if (ndone == 0 && ins_ready) begin
                early_rdy++;
            end
            if (ndone < 2) begin
                @(negedge clk);
                cyc++;
                if (ndone == 1) ins_valid = 1'b0;
            end
        end
        ins_valid = 1'b0;
        chk("held_no_early_accept", early_rdy, 0);
        chk("held_mul_done_cycle", mul_cyc, 7);
        chk("held_ldi_done_cycle", ldi_cyc, 9);
        mr[0] = 8'd15; mr[3] = 8'h77; mres = 8'h77;
        chk("held_result", int'(result), int'(mres));
        check_regs("held_regs");

        // Reset in the middle of a 20-iteration MUL.
        run_ins(4'd7, 2'd0, 2'd0, 8'h0D, gv, ge, gb);
        run_ins(4'd7, 2'd1, 2'd0, 8'h14, gv, ge, gb);
        @(negedge clk);
        ins_op = 4'd8; ins_rd = 2'd0; ins_rs = 2'd1; ins_valid = 1'b1;
        @(negedge clk);
        ins_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midmul_busy_before_reset", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("midmul_ready", int'(ins_ready), 1);
        chk("midmul_busy", int'(busy), 0);
        chk("midmul_done", int'(done), 0);
        chk("midmul_result", int'(result), 0);
        chk("midmul_alu_sel", int'(alu_sel), 0);
        check_regs("midmul_regs");
        npulse = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        chk("midmul_no_done", npulse, 0);

        // Back-to-back stream with ins_valid held high throughout.
        bop[0] = 4'd7; brd[0] = 2'd0; brs[0] = 2'd0; bimm[0] = 8'h11;
        bop[1] = 4'd7; brd[1] = 2'd1; brs[1] = 2'd0; bimm[1] = 8'h22;
        bop[2] = 4'd5; brd[2] = 2'd0; brs[2] = 2'd1; bimm[2] = 8'h00;
        bop[3] = 4'd6; brd[3] = 2'd1; brs[3] = 2'd0; bimm[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            bexp[i] = ref_op(bop[i], mr[brd[i]], mr[brs[i]], bimm[i]);
            mr[brd[i]] = bexp[i];
            acc_cyc[i] = -100;
        end
        mres = bexp[3];
        @(negedge clk);
        k = 0; ndone = 0;
        ins_op = bop[0]; ins_rd = brd[0]; ins_rs = brs[0]; ins_imm = bimm[0];
        ins_valid = 1'b1;
        for (int c = 0; c < 40 && ndone < 4; c++) begin
            rdy = ins_ready;
            @(negedge clk);
            if (done) begin
                if (ndone < 4) chk("b2b_result", int'(result), int'(bexp[ndone]));
                chk("b2b_err", int'(err), 0);
                ndone++;
            end
            if (rdy && ins_valid) begin
                acc_cyc[k] = c;
                k++;
                if (k < 4) begin
                    ins_op = bop[k]; ins_rd = brd[k]; ins_rs = brs[k]; ins_imm = bimm[k];
                end else begin
                    ins_valid = 1'b0;
                end
            end
        end
        ins_valid = 1'b0;
        chk("b2b_accepts", k, 4);
        chk("b2b_dones", ndone, 4);
        for (int i = 1; i < 4; i++) chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 2);
        check_regs("b2b_regs");

        // Random instructions, including illegal opcodes and MUL.
        for (int i = 0; i < 80; i++) begin
            run_ins(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), gv, ge, gb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
